// File: rtl/secant_search_ctrl_if.sv
// ---------------------------------------------------------------------------
// secant_search_ctrl_if
// Handshake/bus bundle between the secant search controller and the analog
// front end plus the host that starts a search.
//   start         : one-cycle search request
//   meas_valid    : q_measured is valid this cycle
//   q_desired     : target measurement (latched by the controller at start)
//   q_measured    : front-end measurement, unsigned
//   i_ref_setup   : first operating point x0 (latched at start)
//   i_ref         : current reference driven into the front end
//   busy/done     : search in progress / search finished
//   converged     : valid with done, tolerance met
//   went_unstable : valid with done, flat slope, stall or iteration limit
//   iter_count    : secant updates performed in the current/last search
// slave modport is the controller side, master is the host/front-end side.
// ---------------------------------------------------------------------------
interface secant_search_ctrl_if #(
    parameter int unsigned BUS_WIDTH = 10,
    parameter int unsigned ITER_W    = 4
);
    logic                 start;
    logic                 meas_valid;
    logic [BUS_WIDTH-1:0] q_desired;
    logic [BUS_WIDTH-1:0] q_measured;
    logic [BUS_WIDTH-1:0] i_ref_setup;
    logic [BUS_WIDTH-1:0] i_ref;
    logic                 busy;
    logic                 done;
    logic                 converged;
    logic                 went_unstable;
    logic [ITER_W-1:0]    iter_count;

    modport slave (
        input  start, meas_valid, q_desired, q_measured, i_ref_setup,
        output i_ref, busy, done, converged, went_unstable, iter_count
    );

    modport master (
        output start, meas_valid, q_desired, q_measured, i_ref_setup,
        input  i_ref, busy, done, converged, went_unstable, iter_count
    );
endinterface

// File: rtl/secant_search_ctrl.sv
// ---------------------------------------------------------------------------
// secant_search_ctrl
// Fixed-point secant search for the front-end current reference. Drives
// i_ref, waits SETTLE_CYCLES after every change, captures the error
// e = q_measured - q_desired on meas_valid and iterates
//   x_new = clamp(x1 - e1*(x1-x0)/(e1-e0))
// until |e| <= TOL, the slope is flat, the update stalls, or MAX_ITER
// updates have been made. The division is a restoring divider producing
// one quotient bit per clock on magnitudes, truncating toward zero.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : secant_search_ctrl_if.slave (handshake, measurement, status)
// ---------------------------------------------------------------------------
module secant_search_ctrl #(
    parameter int unsigned BUS_WIDTH     = 10,
    parameter int unsigned TOL           = 30,
    parameter int unsigned DELTA         = 64,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned MAX_ITER      = 8,
    parameter int unsigned ITER_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    secant_search_ctrl_if.slave  bus
);
    localparam int unsigned W  = BUS_WIDTH;
    localparam int unsigned EW = W + 1;        // error width (signed)
    localparam int unsigned DW = W + 2;        // denominator width (signed)
    localparam int unsigned NW = 2 * W + 2;    // numerator / quotient width
    localparam int unsigned RW = DW + 1;       // partial remainder after shift
    localparam int unsigned XW = NW + 2;       // full-width update before clamp
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CW = $clog2(NW + 1);
    localparam logic [W-1:0] XMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_WAIT, S_EVAL, S_DIVIDE, S_UPDATE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      iref_q, iref_d;
    logic [W-1:0]      x0_q, x0_d;
    logic [W-1:0]      x1_q, x1_d;
    logic [W-1:0]      qd_q, qd_d;
    logic [EW-1:0]     e0_q, e0_d;
    logic [EW-1:0]     e1_q, e1_d;
    logic              pt1_q, pt1_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic [CW-1:0]     dcnt_q, dcnt_d;
    logic [DW-1:0]     rem_q, rem_d;
    logic [NW-1:0]     quo_q, quo_d;
    logic [DW-1:0]     dvsr_q, dvsr_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              conv_q, conv_d;
    logic              unst_q, unst_d;

    logic [W:0]        x1_sum;
    logic [W-1:0]      x1_start;
    logic [EW-1:0]     e_meas;
    logic [EW-1:0]     e_abs;
    logic [EW-1:0]     dx;
    logic [NW-1:0]     num;
    logic [DW-1:0]     den;
    logic [NW-1:0]     num_abs;
    logic [DW-1:0]     den_abs;
    logic [RW-1:0]     shifted;
    logic [RW-1:0]     dvsr_ext;
    logic [XW-1:0]     xfull;
    logic [W-1:0]      xnew;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            iref_q  <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            qd_q    <= '0;
            e0_q    <= '0;
            e1_q    <= '0;
            pt1_q   <= 1'b0;
            iter_q  <= '0;
            scnt_q  <= '0;
            dcnt_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            unst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iref_q  <= iref_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            qd_q    <= qd_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            pt1_q   <= pt1_d;
            iter_q  <= iter_d;
            scnt_q  <= scnt_d;
            dcnt_q  <= dcnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            unst_q  <= unst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iref_d  = iref_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        qd_d    = qd_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        pt1_d   = pt1_q;
        iter_d  = iter_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        conv_d  = conv_q;
        unst_d  = unst_q;

        // Second starting point, saturated at full scale.
        x1_sum   = {1'b0, bus.i_ref_setup} + EW'(DELTA);
        x1_start = x1_sum[W] ? XMAX : x1_sum[W-1:0];

        e_meas = {1'b0, bus.q_measured} - {1'b0, qd_q};
        e_abs  = e1_q[EW-1] ? -e1_q : e1_q;

        // Sign-extended operands: the low NW bits of an unsigned product of
        // two's-complement values equal the signed product.
        dx      = {1'b0, x1_q} - {1'b0, x0_q};
        num     = {{(NW-EW){e1_q[EW-1]}}, e1_q} * {{(NW-EW){dx[EW-1]}}, dx};
        den     = {e1_q[EW-1], e1_q} - {e0_q[EW-1], e0_q};
        num_abs = num[NW-1] ? -num : num;
        den_abs = den[DW-1] ? -den : den;

        shifted  = {rem_q, quo_q[NW-1]};
        dvsr_ext = {1'b0, dvsr_q};

        // x1 - q with q = +/-quo; clamp to [0, XMAX].
        xfull = neg_q ? ({{(XW-W){1'b0}}, x1_q} + {{(XW-NW){1'b0}}, quo_q})
                      : ({{(XW-W){1'b0}}, x1_q} - {{(XW-NW){1'b0}}, quo_q});
        if (xfull[XW-1])
            xnew = '0;
        else if (|xfull[XW-2:W])
            xnew = XMAX;
        else
            xnew = xfull[W-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    qd_d    = bus.q_desired;
                    x0_d    = bus.i_ref_setup;
                    x1_d    = x1_start;
                    iref_d  = bus.i_ref_setup;
                    pt1_d   = 1'b0;
                    iter_d  = '0;
                    scnt_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    conv_d  = 1'b0;
                    unst_d  = 1'b0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (scnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    scnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            S_WAIT: begin
                if (bus.meas_valid) begin
                    e1_d    = e_meas;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (e_abs <= EW'(TOL)) begin
                    conv_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (!pt1_q) begin
                    e0_d    = e1_q;
                    pt1_d   = 1'b1;
                    iref_d  = x1_q;
                    state_d = S_SETTLE;
                end else if (iter_q == ITER_W'(MAX_ITER)) begin
                    unst_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dcnt_d  = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                // Count 0 loads magnitudes (or bails on a flat slope);
                // counts 1..NW each retire one quotient bit.
                if (dcnt_q == '0) begin
                    if (den == '0) begin
                        unst_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        quo_d  = num_abs;
                        rem_d  = '0;
                        dvsr_d = den_abs;
                        neg_d  = num[NW-1] ^ den[DW-1];
                        dcnt_d = CW'(1);
                    end
                end else begin
                    if (shifted >= dvsr_ext) begin
                        rem_d = DW'(shifted - dvsr_ext);
                        quo_d = {quo_q[NW-2:0], 1'b1};
                    end else begin
                        rem_d = DW'(shifted);
                        quo_d = {quo_q[NW-2:0], 1'b0};
                    end
                    if (dcnt_q == CW'(NW))
                        state_d = S_UPDATE;
                    else
                        dcnt_d = dcnt_q + CW'(1);
                end
            end
            S_UPDATE: begin
                if (xnew == x1_q) begin
                    unst_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    x0_d    = x1_q;
                    e0_d    = e1_q;
                    x1_d    = xnew;
                    iref_d  = xnew;
                    iter_d  = iter_q + ITER_W'(1);
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.i_ref         = iref_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.converged     = conv_q;
    assign bus.went_unstable = unst_q;
    assign bus.iter_count    = iter_q;
endmodule

// File: tb/tb_secant_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_secant_search_ctrl
// Self-checking bench for secant_search_ctrl. Two instances share stimulus:
// dut0 with MAX_ITER=8, dut1 with MAX_ITER=1; use1 selects which one is
// observed. A plant model turns i_ref into q_measured; meas_valid pulses
// every third cycle. Every change of the observed i_ref is checked against
// a queue of expected operating points, and final status is checked against
// a queue of expected results pushed when each search is launched.
// ---------------------------------------------------------------------------
module tb_secant_search_ctrl;
    localparam int unsigned BW = 10;
    localparam int unsigned IW = 4;

    typedef struct {
        int conv;
        int unst;
        int iter;
        int iref;
    } res_t;

    typedef struct {
        string name;
        bit    rst_first;
        bit    use1;
        int    psel;
        int    setup;
        int    qd;
        int    nref;
        int    r0;
        int    r1;
        int    r2;
        res_t  exp;
    } vec_t;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          start  = 1'b0;
    logic          mv     = 1'b0;
    logic          glitch = 1'b0;
    logic          use1   = 1'b0;
    logic [BW-1:0] qd     = '0;
    logic [BW-1:0] setup  = '0;
    int            psel   = 0;
    int            mv_n   = 0;
    int            checks = 0;
    int            errors = 0;
    int            e_ref;
    logic [BW-1:0] prev_iref = '0;
    res_t          exp_q[$];
    int            iref_q[$];
    vec_t          vecs[5];

    always #5 clk = ~clk;

    secant_search_ctrl_if #(.BUS_WIDTH(BW), .ITER_W(IW)) bus0 ();
    secant_search_ctrl_if #(.BUS_WIDTH(BW), .ITER_W(IW)) bus1 ();

    secant_search_ctrl #(.BUS_WIDTH(BW), .TOL(30), .DELTA(64), .SETTLE_CYCLES(16),
                         .MAX_ITER(8), .ITER_W(IW))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    secant_search_ctrl #(.BUS_WIDTH(BW), .TOL(30), .DELTA(64), .SETTLE_CYCLES(16),
                         .MAX_ITER(1), .ITER_W(IW))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // 0: q = i/2 + 10, 1: q = 300, 2: q = (i*i) >> 10
    function automatic logic [BW-1:0] plant(input int sel, input logic [BW-1:0] i);
        int v;
        case (sel)
            0:       v = int'(i) / 2 + 10;
            1:       v = 300;
            default: v = (int'(i) * int'(i)) >>> 10;
        endcase
        return BW'(v);
    endfunction

    assign bus0.start       = start;
    assign bus0.meas_valid  = mv;
    assign bus0.q_desired   = qd;
    assign bus0.i_ref_setup = setup;
    assign bus0.q_measured  = glitch ? '0 : plant(psel, bus0.i_ref);
    assign bus1.start       = start;
    assign bus1.meas_valid  = mv;
    assign bus1.q_desired   = qd;
    assign bus1.i_ref_setup = setup;
    assign bus1.q_measured  = glitch ? '0 : plant(psel, bus1.i_ref);

    logic [BW-1:0] s_iref;
    logic          s_busy, s_done, s_conv, s_unst;
    logic [IW-1:0] s_iter;
    assign s_iref = use1 ? bus1.i_ref         : bus0.i_ref;
    assign s_busy = use1 ? bus1.busy          : bus0.busy;
    assign s_done = use1 ? bus1.done          : bus0.done;
    assign s_conv = use1 ? bus1.converged     : bus0.converged;
    assign s_unst = use1 ? bus1.went_unstable : bus0.went_unstable;
    assign s_iter = use1 ? bus1.iter_count    : bus0.iter_count;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    function automatic vec_t mk(input string nm, input bit rf, input bit u1, input int ps,
                                input int su, input int q, input int nr, input int a,
                                input int b, input int c, input int cv, input int us,
                                input int it, input int ir);
        vec_t v;
        v.name = nm; v.rst_first = rf; v.use1 = u1; v.psel = ps;
        v.setup = su; v.qd = q; v.nref = nr; v.r0 = a; v.r1 = b; v.r2 = c;
        v.exp.conv = cv; v.exp.unst = us; v.exp.iter = it; v.exp.iref = ir;
        return v;
    endfunction

    // meas_valid pulses every third cycle, independent of the DUT state.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mv = (mv_n % 3 == 0);
            mv_n++;
        end
    end

    // i_ref scoreboard: each observed change must match the next expected point.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_iref = '0;
            end else if (s_iref !== prev_iref) begin
                checks++;
                if (iref_q.size() == 0) begin
                    errors++;
                    $display("FAIL iref_seq: got %0d, expected no further change", s_iref);
                end else begin
                    e_ref = iref_q.pop_front();
                    if (int'(s_iref) != e_ref) begin
                        errors++;
                        $display("FAIL iref_seq: got %0d, expected %0d", s_iref, e_ref);
                    end
                end
                prev_iref = s_iref;
            end
        end
    end

    // Called half-way between edges; drops reset asynchronously mid-cycle.
    task automatic do_reset(input string name);
        #2;
        rst = 1'b0;
        #1;
        chk({name, "/i_ref"},     s_iref, 0);
        chk({name, "/busy"},      s_busy, 0);
        chk({name, "/done"},      s_done, 0);
        chk({name, "/converged"}, s_conv, 0);
        chk({name, "/unstable"},  s_unst, 0);
        chk({name, "/iter"},      s_iter, 0);
        exp_q.delete();
        iref_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic launch(input vec_t v);
        if (v.nref > 0) iref_q.push_back(v.r0);
        if (v.nref > 1) iref_q.push_back(v.r1);
        if (v.nref > 2) iref_q.push_back(v.r2);
        exp_q.push_back(v.exp);
        use1  = v.use1;
        psel  = v.psel;
        qd    = BW'(v.qd);
        setup = BW'(v.setup);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({v.name, "/busy_after_start"}, s_busy, 1);
        chk({v.name, "/done_after_start"}, s_done, 0);
    endtask

    task automatic finish_run(input string name);
        res_t e;
        int   n;
        n = 0;
        while (!s_done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_done) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: done=0 after %0d cycles, expected done=1", name, n);
            exp_q.delete();
            iref_q.delete();
        end else begin
            e = exp_q.pop_front();
            chk({name, "/converged"},    s_conv, e.conv);
            chk({name, "/unstable"},     s_unst, e.unst);
            chk({name, "/iter"},         s_iter, e.iter);
            chk({name, "/i_ref"},        s_iref, e.iref);
            chk({name, "/busy"},         s_busy, 0);
            chk({name, "/pending_iref"}, iref_q.size(), 0);
        end
    endtask

    initial begin
        int n;
        //            name              rst u1 plant setup qd   n  r0   r1   r2   cv us it iref
        vecs[0] = mk("linear_conv",     1, 0, 0,   100, 260, 3, 100, 164, 500, 1, 0, 1, 500);
        vecs[1] = mk("x0_tol_boundary", 0, 0, 0,   100, 90,  1, 100, 0,   0,   1, 0, 0, 100);
        vecs[2] = mk("flat_slope",      1, 0, 1,   100, 260, 2, 100, 164, 0,   0, 1, 0, 164);
        vecs[3] = mk("clamp_stall",     1, 0, 0,   100, 1000,3, 100, 164, 1023,0, 1, 1, 1023);
        vecs[4] = mk("quad_max_iter",   1, 1, 2,   100, 100, 3, 100, 164, 442, 0, 1, 1, 442);

        @(posedge clk); #1;
        do_reset("por");

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].rst_first) do_reset({vecs[i].name, "/reset"});
            launch(vecs[i]);
            finish_run(vecs[i].name);
        end

        // Reset while settling on x0.
        do_reset("pre_settle_abort");
        launch(vecs[0]);
        repeat (5) begin @(posedge clk); #1; end
        chk("settle_abort/busy", s_busy, 1);
        do_reset("rst_mid_settle");

        // Reset while the divider is running on the first update.
        launch(vecs[0]);
        n = 0;
        while (s_iref != BW'(164) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("divide_abort/x1_reached", s_iref, 164);
        repeat (30) begin @(posedge clk); #1; end
        chk("divide_abort/busy", s_busy, 1);
        chk("divide_abort/done", s_done, 0);
        do_reset("rst_mid_divide");

        // Bogus measurements during SETTLE and a start while busy are ignored.
        glitch = 1'b1;
        launch(vecs[0]);
        repeat (4) begin @(posedge clk); #1; end
        qd    = BW'(90);
        setup = BW'(500);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        qd    = BW'(260);
        setup = BW'(100);
        repeat (5) begin @(posedge clk); #1; end
        glitch = 1'b0;
        finish_run("after_reset_glitch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/secant_search_ctrl.md
Name: secant_search_ctrl

Overview:
- Fixed-point, handshaked successor to the front-end secant current-reference controller.
- Drives `i_ref` into the analog front end and waits a programmable settle time after each change. It then captures `q_measured` on `meas_valid` and iterates the secant update until `|q_measured - q_desired| <= TOL`.
- Uses no `real` arithmetic: a sequential signed divider, output clamping, and an iteration limit replace the free-running state counter.

Parameters:
- BUS_WIDTH, 10, width of `q_desired`, `q_measured`, `i_ref_setup`, `i_ref`
- TOL, 30, convergence tolerance in LSB of q (inclusive)
- DELTA, 64, offset of the second starting point: `x1 = clamp(i_ref_setup + DELTA)`
- SETTLE_CYCLES, 16, clocks to wait after each `i_ref` change before accepting a measurement
- MAX_ITER, 8, maximum secant updates before giving up
- ITER_W, 4, width of `iter_count` (must hold MAX_ITER)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; accepted only in IDLE or DONE
- meas_valid  input  1  `q_measured` valid this cycle
- q_desired  input  BUS_WIDTH  target measurement, latched at start
- q_measured  input  BUS_WIDTH  front-end measurement (unsigned)
- i_ref_setup  input  BUS_WIDTH  first operating point x0, latched at start
- i_ref  output  BUS_WIDTH  current reference to front end
- busy  output  1  search in progress
- done  output  1  high in DONE until next accepted start
- converged  output  1  valid when done; 1 = tolerance met
- went_unstable  output  1  valid when done; 1 = flat slope, stall, or MAX_ITER hit
- iter_count  output  ITER_W  secant updates performed in the current or last search

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; `i_ref`, `busy`, `done`, `converged`, `went_unstable`, `iter_count` all 0; internal registers cleared.
- Reset mid-search: takes effect immediately; no measurement is completed.
- States:
  - IDLE/DONE: on start, latch inputs; set `i_ref = x0`; clear flags and `iter_count`; `busy = 1`; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES clocks, then go to WAIT_MEAS. `meas_valid` is ignored while in SETTLE.
  - WAIT_MEAS: on the first `meas_valid`, capture `e = q_measured - q_desired` (signed, BUS_WIDTH+1); go to EVAL.
  - EVAL:
    - If `|e| <= TOL`: converged=1, go to DONE.
    - Else, if this was point 0: store `(x0, e0)`, set `i_ref = x1`, go to SETTLE.
    - Else: if `iter_count == MAX_ITER`, set went_unstable=1 and go to DONE; otherwise go to DIVIDE.
  - DIVIDE:
    - `num = e1 * (x1 - x0)` (signed, 2·BUS_WIDTH+2); `den = e1 - e0` (signed, BUS_WIDTH+2).
    - If `den == 0`: went_unstable=1, go to DONE.
    - Otherwise run a restoring divider on the magnitudes, one quotient bit per clock (2·BUS_WIDTH+2 clocks), then apply the sign. The quotient truncates toward zero.
  - UPDATE:
    - `x_new = clamp(x1 - q, 0, 2^BUS_WIDTH - 1)`, computed at full width before clamping.
    - If `x_new == x1`: stall, went_unstable=1, go to DONE.
    - Else `x0 <= x1`, `e0 <= e1`, `x1 <= x_new`, `i_ref <= x_new`, `iter_count++`; go to SETTLE.
- Tolerance is checked on every measurement, including x0 and x1.
- `x1` is clamped to `2^BUS_WIDTH - 1`.
- DONE: `busy = 0`, `done = 1`; `i_ref` holds its last driven value; `converged` and `went_unstable` are mutually exclusive.
- `start` while busy is ignored. `start` in DONE restarts the search in the same cycle.
- `i_ref` changes only on entry to SETTLE or on reset.

Test Plan (BUS_WIDTH=10, TOL=30, DELTA=64, MAX_ITER=8 unless stated):
- Linear plant `q = i/2 + 10`, `i_ref_setup = 100`, `q_desired = 260` -> `i_ref` sequence 100, 164, 500; done, converged=1, iter_count=1, final q=260.
- Same plant, `q_desired = 90` -> converges on x0 (`|e| = 30`, inclusive boundary); `i_ref = 100`, iter_count=0, no second point driven.
- Flat plant `q = 300` -> `e0 == e1`; went_unstable=1, converged=0, `i_ref = 164`, iter_count=0.
- Linear plant, `q_desired = 1000` -> first update clamps to 1023 (iter_count=1). The second update computes 1982, which clamps to 1023 = x1, a stall: went_unstable=1, `i_ref = 1023`.
- Quadratic plant `q = (i*i) >> 10`, `q_desired = 100`, MAX_ITER=1 -> x_new = 442, q=190, `|e| = 90`; went_unstable=1, iter_count=1, `i_ref = 442`.
- Drop rst mid-SETTLE, and separately mid-DIVIDE -> all outputs 0 asynchronously. After release, a new start with `meas_valid` pulses inside SETTLE ignored runs a normal search.
